tap_window_loader: RTL and testbench



---
 rtl/tap_window_loader.sv | 100 ++++++++++
 tb/tb_tap_window_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_window_loader.sv
// Sample delay line feeding the FIR tap window: shifts in one sample per strobe,
// tracks fill level and issues a start pulse on the full window, then every STRIDE-th accept.
module tap_window_loader #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int STRIDE        = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BITS_PER_ELEM-1:0]          i_sample,
  input  logic                              i_valid,
  input  logic                              i_flush,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_start_calc,
  output logic                              o_full,
  output logic [$clog2(NUM_ELEM+1)-1:0]     o_fill_count
);

  localparam int CNT_W = $clog2(NUM_ELEM + 1);
  localparam int STR_W = $clog2(STRIDE + 1);
  localparam int TAP_W = NUM_ELEM * BITS_PER_ELEM;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(NUM_ELEM);
  localparam logic [STR_W-1:0] STR_LAST  = STR_W'(STRIDE - 1);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [TAP_W-1:0]         r_taps;
  logic [CNT_W-1:0]         r_fill, w_fill_nxt;
  logic [STR_W-1:0]         r_stride, w_stride_nxt;
  logic                     r_start, w_start_nxt;
  logic                     w_accept;

  assign w_accept = i_valid & ~i_flush;

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_nxt   = r_fill;
    w_stride_nxt = r_stride;
    w_start_nxt  = 1'b0;
    if (i_flush) begin
      w_state_nxt  = S_FILL;
      w_fill_nxt   = '0;
      w_stride_nxt = '0;
    end else if (i_valid) begin
      unique case (r_state)
        S_FILL: begin
          if (r_fill == FILL_LAST) begin
            w_state_nxt  = S_RUN;
            w_fill_nxt   = FILL_MAX;
            w_stride_nxt = '0;
            w_start_nxt  = 1'b1;
          end else begin
            w_fill_nxt = r_fill + 1'b1;
          end
        end
        S_RUN: begin
          // Counter wraps one short of STRIDE so the pulse lands on the STRIDE-th accept.
          if (r_stride == STR_LAST) begin
            w_stride_nxt = '0;
            w_start_nxt  = 1'b1;
          end else begin
            w_stride_nxt = r_stride + 1'b1;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FILL;
      r_taps   <= '0;
      r_fill   <= '0;
      r_stride <= '0;
      r_start  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fill   <= w_fill_nxt;
      r_stride <= w_stride_nxt;
      r_start  <= w_start_nxt;
      if (i_flush) begin
        r_taps <= '0;
      end else if (w_accept) begin
        r_taps <= {r_taps[TAP_W-BITS_PER_ELEM-1:0], i_sample};
      end
    end
  end

  assign o_taps       = r_taps;
  assign o_start_calc = r_start;
  assign o_full       = (r_state == S_RUN);
  assign o_fill_count = r_fill;

endmodule

// File: tb/tb_tap_window_loader.sv
// Bench for tap_window_loader: two instances (STRIDE=1 and STRIDE=3) share stimulus;
// a reference model pushes expected outputs per driven cycle and a monitor pops/compares them.
module tb_tap_window_loader;

  localparam int B = 8;
  localparam int N = 7;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [B-1:0]    i_sample = '0;
  logic            i_valid = 1'b0;
  logic            i_flush = 1'b0;
  logic [N*B-1:0]  taps1, taps3;
  logic            start1, start3, full1, full3;
  logic [CW-1:0]   fill1, fill3;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses1 = 0;
  int unsigned pulses3 = 0;

  typedef struct {
    logic [N*B-1:0] taps;
    logic [CW-1:0]  fill;
    logic           full;
    logic           st1;
    logic           st3;
  } exp_t;

  exp_t exp_q[$];

  logic [B-1:0] m_taps[N];
  int unsigned  m_fill = 0;
  int unsigned  m_s1 = 0;
  int unsigned  m_s3 = 0;

  always #5 clk = ~clk;

  tap_window_loader #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .i_sample(i_sample), .i_valid(i_valid), .i_flush(i_flush),
    .o_taps(taps1), .o_start_calc(start1), .o_full(full1), .o_fill_count(fill1));

  tap_window_loader #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .STRIDE(3)) dut3 (
    .clk(clk), .reset(reset), .i_sample(i_sample), .i_valid(i_valid), .i_flush(i_flush),
    .o_taps(taps3), .o_start_calc(start3), .o_full(full3), .o_fill_count(fill3));

  // Drive one cycle and push the model's expected post-edge outputs.
  task automatic drive(input logic rst, input logic v, input logic f, input logic [B-1:0] s);
    exp_t e;
    @(negedge clk);
    reset = rst; i_valid = v; i_flush = f; i_sample = s;
    e.st1 = 1'b0;
    e.st3 = 1'b0;
    if (rst || f) begin
      for (int k = 0; k < N; k++) m_taps[k] = '0;
      m_fill = 0; m_s1 = 0; m_s3 = 0;
    end else if (v) begin
      for (int k = N - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
      m_taps[0] = s;
      if (m_fill < N) begin
        m_fill++;
        if (m_fill == N) begin
          e.st1 = 1'b1; e.st3 = 1'b1; m_s1 = 0; m_s3 = 0;
        end
      end else begin
        m_s1++;
        if (m_s1 == 1) begin e.st1 = 1'b1; m_s1 = 0; end
        m_s3++;
        if (m_s3 == 3) begin e.st3 = 1'b1; m_s3 = 0; end
      end
    end
    for (int k = 0; k < N; k++) e.taps[k*B +: B] = m_taps[k];
    e.fill = CW'(m_fill);
    e.full = (m_fill == N);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, B'($urandom));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (start1) pulses1++;
    if (start3) pulses3++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (taps1 !== e.taps) begin errors++; $display("FAIL taps1 got %h exp %h", taps1, e.taps); end
      checks++;
      if (taps3 !== e.taps) begin errors++; $display("FAIL taps3 got %h exp %h", taps3, e.taps); end
      checks++;
      if (fill1 !== e.fill || fill3 !== e.fill) begin
        errors++; $display("FAIL fill got %0d/%0d exp %0d", fill1, fill3, e.fill);
      end
      checks++;
      if (full1 !== e.full || full3 !== e.full) begin
        errors++; $display("FAIL full got %b/%b exp %b", full1, full3, e.full);
      end
      checks++;
      if (start1 !== e.st1) begin errors++; $display("FAIL start1 got %b exp %b", start1, e.st1); end
      checks++;
      if (start3 !== e.st3) begin errors++; $display("FAIL start3 got %b exp %b", start3, e.st3); end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    checks++;
    if (taps1 !== '0 || start1 !== 1'b0 || full1 !== 1'b0 || fill1 !== '0) begin
      errors++; $display("FAIL reset_state got taps=%h st=%b full=%b fill=%0d exp zeros", taps1, start1, full1, fill1);
    end
  endtask

  task automatic test_fill();
    int unsigned p0;
    p0 = pulses1;
    for (int i = 1; i <= N; i++) drive(1'b0, 1'b1, 1'b0, B'(i));
    settle();
    checks++;
    if (taps1 !== 56'h01020304050607) begin errors++; $display("FAIL fill_window got %h exp 01020304050607", taps1); end
    checks++;
    if (pulses1 - p0 != 1 || start1 !== 1'b1 || full1 !== 1'b1) begin
      errors++; $display("FAIL fill_pulse got pulses=%0d st=%b full=%b exp 1/1/1", pulses1 - p0, start1, full1);
    end
  endtask

  task automatic test_idle_run();
    int unsigned p0;
    p0 = pulses1;
    drive(1'b0, 1'b1, 1'b0, 8'd8);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 8'd9);
    idle(3);
    settle();
    checks++;
    if (taps1 !== 56'h03040506070809) begin errors++; $display("FAIL run_window got %h exp 03040506070809", taps1); end
    checks++;
    if (pulses1 - p0 != 2) begin errors++; $display("FAIL run_pulses got %0d exp 2", pulses1 - p0); end
  endtask

  task automatic test_stride3();
    int unsigned p0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    p0 = pulses3;
    for (int i = 1; i <= 13; i++) drive(1'b0, 1'b1, 1'b0, B'(i));
    idle(2);
    settle();
    checks++;
    if (pulses3 - p0 != 3) begin errors++; $display("FAIL stride3_pulses got %0d exp 3", pulses3 - p0); end
    checks++;
    if (taps3 !== 56'h0708090A0B0C0D) begin errors++; $display("FAIL stride3_window got %h exp 0708090a0b0c0d", taps3); end
  endtask

  task automatic test_flush();
    int unsigned p0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 1'b0, B'(i));
    drive(1'b0, 1'b1, 1'b1, 8'h55);
    settle();
    checks++;
    if (taps1 !== '0 || fill1 !== '0 || full1 !== 1'b0) begin
      errors++; $display("FAIL flush got taps=%h fill=%0d full=%b exp 0/0/0", taps1, fill1, full1);
    end
    p0 = pulses1;
    for (int i = 1; i <= N - 1; i++) drive(1'b0, 1'b1, 1'b0, B'(8'h20 + i));
    settle();
    checks++;
    if (pulses1 != p0) begin errors++; $display("FAIL flush_early_pulse got %0d exp 0", pulses1 - p0); end
    drive(1'b0, 1'b1, 1'b0, 8'h27);
    settle();
    checks++;
    if (pulses1 - p0 != 1 || taps1 !== 56'h21222324252627) begin
      errors++; $display("FAIL flush_refill got pulses=%0d taps=%h exp 1/21222324252627", pulses1 - p0, taps1);
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned p0;
    p0 = pulses1;
    drive(1'b1, 1'b1, 1'b0, 8'hAA);
    settle();
    checks++;
    if (taps1 !== '0 || start1 !== 1'b0 || full1 !== 1'b0 || fill1 !== '0 || pulses1 != p0) begin
      errors++; $display("FAIL reset_midrun got taps=%h st=%b full=%b fill=%0d exp zeros", taps1, start1, full1, fill1);
    end
    test_fill();
  endtask

  task automatic test_signed();
    logic [B-1:0] pat[N];
    pat = '{8'h80, 8'hFF, 8'h7F, 8'h01, 8'hFE, 8'h00, 8'h81};
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < N; i++) drive(1'b0, 1'b1, 1'b0, pat[i]);
    settle();
    checks++;
    if (taps1 !== 56'h80FF7F01FE0081) begin errors++; $display("FAIL signed_window got %h exp 80ff7f01fe0081", taps1); end
  endtask

  task automatic test_back_to_back();
    int unsigned p0;
    p0 = pulses1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, B'($urandom));
    idle(1);
    settle();
    checks++;
    if (pulses1 - p0 != 5) begin errors++; $display("FAIL b2b_pulses got %0d exp 5", pulses1 - p0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_idle_run();
    test_stride3();
    test_flush();
    test_reset_midrun();
    test_signed();
    test_back_to_back();
    idle(2);
    settle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
